// File: rtl/param_code_lock_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_code_lock_if : key/code/relock inputs and status outputs of the lock |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface param_code_lock_if #(
  parameter int KEY_W    = 4,
  parameter int SEQ_LEN  = 4,
  parameter int MAX_FAIL = 3
);
  logic [KEY_W-1:0]                 keys;
  logic [SEQ_LEN*KEY_W-1:0]         code;
  logic                             relock;
  logic                             unlock;
  logic [SEQ_LEN-1:0]               progress;
  logic                             locked_out;
  logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt;

  modport master (
    output keys, code, relock,
    input  unlock, progress, locked_out, fail_cnt
  );

  modport slave (
    input  keys, code, relock,
    output unlock, progress, locked_out, fail_cnt
  );
endinterface
`default_nettype wire

// File: rtl/param_code_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_code_lock : Moore keypad lock with timed unlock and failure lockout  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module param_code_lock #(
  parameter int KEY_W       = 4,
  parameter int SEQ_LEN     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int UNLOCK_CYC  = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  param_code_lock_if.slave   bus
);

  localparam int c_IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int c_FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int c_TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_IDX_W-1:0]  c_IDX_LAST    = c_IDX_W'(SEQ_LEN - 1);
  localparam logic [c_FAIL_W-1:0] c_FAIL_MAX    = c_FAIL_W'(MAX_FAIL);
  localparam logic [c_FAIL_W-1:0] c_FAIL_LAST   = c_FAIL_W'(MAX_FAIL - 1);
  localparam logic [c_TMR_W-1:0]  c_UNLOCK_LOAD = c_TMR_W'(UNLOCK_CYC);
  localparam logic [c_TMR_W-1:0]  c_LOCK_LOAD   = c_TMR_W'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_UNLOCK  = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [c_IDX_W-1:0]  r_idx,   w_idx_nx;
  logic [c_FAIL_W-1:0] r_fail,  w_fail_nx;
  logic [c_TMR_W-1:0]  r_timer, w_timer_nx;
  logic [KEY_W-1:0]    w_exp;

  assign w_exp = bus.code[int'(r_idx) * KEY_W +: KEY_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_ENTRY;
      r_idx   <= '0;
      r_fail  <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_fail  <= w_fail_nx;
      r_timer <= w_timer_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_fail_nx  = r_fail;
    w_timer_nx = r_timer;
    case (r_state)
      S_ENTRY: begin
        // relock wins over a key arriving in the same cycle
        if (bus.relock) begin
          w_idx_nx = '0;
        end else if (bus.keys != '0) begin
          if (bus.keys == w_exp) begin
            if (r_idx == c_IDX_LAST) begin
              w_state_nx = S_UNLOCK;
              w_idx_nx   = '0;
              w_fail_nx  = '0;
              w_timer_nx = c_UNLOCK_LOAD;
            end else begin
              w_idx_nx = r_idx + 1'b1;
            end
          end else begin
            w_idx_nx = '0;
            if (r_fail == c_FAIL_LAST) begin
              w_state_nx = S_LOCKOUT;
              w_fail_nx  = c_FAIL_MAX;
              w_timer_nx = c_LOCK_LOAD;
            end else if (r_fail != c_FAIL_MAX) begin
              w_fail_nx = r_fail + 1'b1;
            end
          end
        end
      end
      S_UNLOCK: begin
        if (bus.relock) begin
          w_state_nx = S_ENTRY;
          w_timer_nx = '0;
        end else if (UNLOCK_CYC != 0) begin
          // timer reads 1 in the last unlocked cycle
          if (r_timer <= c_TMR_W'(1)) begin
            w_state_nx = S_ENTRY;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = r_timer - 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nx = S_ENTRY;
          w_idx_nx   = '0;
          w_fail_nx  = '0;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nx = S_ENTRY;
        w_idx_nx   = '0;
        w_fail_nx  = '0;
        w_timer_nx = '0;
      end
    endcase
  end

  assign bus.unlock     = (r_state == S_UNLOCK);
  assign bus.locked_out = (r_state == S_LOCKOUT);
  assign bus.fail_cnt   = r_fail;

  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_prog
    assign bus.progress[i] = (r_state == S_UNLOCK) ||
                             ((r_state == S_ENTRY) && (int'(r_idx) > i));
  end

endmodule
`default_nettype wire

// File: tb/tb_param_code_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_param_code_lock : directed vector table plus multi-cycle corner cases   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_param_code_lock;

  localparam logic [15:0] c_CODE = {4'b0010, 4'b1000, 4'b0100, 4'b0001};

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  param_code_lock_if #(.KEY_W(4), .SEQ_LEN(4), .MAX_FAIL(3)) ifc ();

  param_code_lock #(
    .KEY_W(4), .SEQ_LEN(4), .MAX_FAIL(3), .LOCKOUT_CYC(16), .UNLOCK_CYC(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;
    logic       relock;
    logic       unlock;
    logic [3:0] prog;
    logic       lo;
    logic [1:0] fail;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] k, input logic rl, input logic u,
                     input logic [3:0] p, input logic lo, input logic [1:0] f);
    vec_t v;
    v.keys = k; v.relock = rl; v.unlock = u; v.prog = p; v.lo = lo; v.fail = f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic u, input logic [3:0] p,
                         input logic lo, input logic [1:0] f);
    chk({name, ".unlock"},     32'(ifc.unlock),     32'(u));
    chk({name, ".progress"},   32'(ifc.progress),   32'(p));
    chk({name, ".locked_out"}, 32'(ifc.locked_out), 32'(lo));
    chk({name, ".fail_cnt"},   32'(ifc.fail_cnt),   32'(f));
  endtask

  task automatic step(input logic [3:0] k, input logic rl);
    ifc.keys   = k;
    ifc.relock = rl;
    @(posedge clk);
    #1;
    ifc.keys   = 4'b0000;
    ifc.relock = 1'b0;
  endtask

  task automatic enter_code();
    step(4'b0001, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0010, 1'b0);
  endtask

  initial begin
    ifc.keys   = 4'b0000;
    ifc.relock = 1'b0;
    ifc.code   = c_CODE;
    reset      = 1'b0;
    #2;
    chk_all("reset", 1'b0, 4'b0000, 1'b0, 2'd0);
    #10 reset = 1'b1;

    // correct sequence with gaps, unlock for 8 cycles (one ignored key inside)
    add(4'b0001, 0, 0, 4'b0001, 0, 2'd0);
    add(4'b0000, 0, 0, 4'b0001, 0, 2'd0);
    add(4'b0100, 0, 0, 4'b0011, 0, 2'd0);
    add(4'b0000, 0, 0, 4'b0011, 0, 2'd0);
    add(4'b1000, 0, 0, 4'b0111, 0, 2'd0);
    add(4'b0010, 0, 1, 4'b1111, 0, 2'd0);
    add(4'b0000, 0, 1, 4'b1111, 0, 2'd0);
    add(4'b1000, 0, 1, 4'b1111, 0, 2'd0);
    for (int i = 0; i < 5; i++) add(4'b0000, 0, 1, 4'b1111, 0, 2'd0);
    add(4'b0000, 0, 0, 4'b0000, 0, 2'd0);
    // wrong key restarts without re-evaluating it
    add(4'b0001, 0, 0, 4'b0001, 0, 2'd0);
    add(4'b0100, 0, 0, 4'b0011, 0, 2'd0);
    add(4'b0001, 0, 0, 4'b0000, 0, 2'd1);
    add(4'b0001, 0, 0, 4'b0001, 0, 2'd1);
    // relock in entry drops progress, ignores the key, keeps fail_cnt
    add(4'b0100, 1, 0, 4'b0000, 0, 2'd1);
    add(4'b0000, 0, 0, 4'b0000, 0, 2'd1);

    foreach (vecs[i]) begin
      step(vecs[i].keys, vecs[i].relock);
      chk_all($sformatf("vec%0d", i), vecs[i].unlock, vecs[i].prog, vecs[i].lo, vecs[i].fail);
    end

    // async reset between edges clears fail_cnt
    #2 reset = 1'b0;
    #1 chk_all("rst_clr", 1'b0, 4'b0000, 1'b0, 2'd0);
    #1 reset = 1'b1;

    // lockout: exactly 16 cycles, correct code during it is ignored
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("lock_pre.fail_cnt", 32'(ifc.fail_cnt), 32'd2);
    step(4'b1000, 1'b0);
    chk_all("lock_first", 1'b0, 4'b0000, 1'b1, 2'd3);
    for (int j = 1; j < 16; j++) begin
      step((j % 4 == 1) ? 4'b0001 : (j % 4 == 2) ? 4'b0100 :
           (j % 4 == 3) ? 4'b1000 : 4'b0010, 1'b0);
      chk($sformatf("lock_cyc%0d", j), 32'(ifc.locked_out), 32'd1);
    end
    step(4'b0000, 1'b0);
    chk_all("lock_end", 1'b0, 4'b0000, 1'b0, 2'd0);
    enter_code();
    chk_all("post_lock_unlock", 1'b1, 4'b1111, 1'b0, 2'd0);

    // relock sampled in the 3rd unlock cycle
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("relock_c3.unlock", 32'(ifc.unlock), 32'd1);
    step(4'b0000, 1'b1);
    chk_all("relock", 1'b0, 4'b0000, 1'b0, 2'd0);

    // reset mid-sequence
    step(4'b0001, 1'b0);
    step(4'b0100, 1'b0);
    chk("mid.progress", 32'(ifc.progress), 32'b0011);
    #2 reset = 1'b0;
    #1 chk_all("rst_mid", 1'b0, 4'b0000, 1'b0, 2'd0);
    #1 reset = 1'b1;
    step(4'b0100, 1'b0);
    chk_all("rst_mid_idx0", 1'b0, 4'b0000, 1'b0, 2'd1);

    // reset during lockout
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("rst_lo.pre", 32'(ifc.locked_out), 32'd1);
    #2 reset = 1'b0;
    #1 chk_all("rst_lo", 1'b0, 4'b0000, 1'b0, 2'd0);
    #1 reset = 1'b1;
    step(4'b0001, 1'b0);
    chk_all("rst_lo_idx0", 1'b0, 4'b0001, 1'b0, 2'd0);

    // code change mid-sequence affects only the next key
    ifc.code[7:4] = 4'b0011;
    step(4'b0011, 1'b0);
    chk_all("code_chg", 1'b0, 4'b0011, 1'b0, 2'd0);
    ifc.code = c_CODE;
    step(4'b0000, 1'b1);

    // success clears fail_cnt; next wrong key counts from zero
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("clr.fail2", 32'(ifc.fail_cnt), 32'd2);
    enter_code();
    chk_all("clr_unlock", 1'b1, 4'b1111, 1'b0, 2'd0);
    for (int j = 0; j < 8; j++) step(4'b0000, 1'b0);
    chk("clr_relocked", 32'(ifc.unlock), 32'd0);
    step(4'b1000, 1'b0);
    chk_all("clr_wrong", 1'b0, 4'b0000, 1'b0, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
